// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module   : life_pkg
// Brief    : Shared types and constants for the Life generation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package life_pkg;

  localparam int GRID_DIM  = 16;
  localparam int GRID_BITS = GRID_DIM * GRID_DIM;

  // Row r occupies bits [255-16r -: 16].
  typedef logic [GRID_BITS-1:0] grid_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STEP  = 2'd1,
    OP_RUN   = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_STEP = 2'd2,
    S_RUN  = 2'd3
  } seq_state_t;

  typedef enum logic [2:0] {
    STOP_NONE    = 3'd0,
    STOP_HALT    = 3'd1,
    STOP_LIMIT   = 3'd2,
    STOP_EXTINCT = 3'd3,
    STOP_STILL   = 3'd4,
    STOP_PERIOD2 = 3'd5
  } stop_code_t;

endpackage
`default_nettype wire

// File: rtl/life_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : life_tick_div
// Brief    : Generation tick divider. Pulses tick when the counter reaches
//            TICK_DIV-1 while enabled, then wraps to zero.
// Revision : 1.0 - initial release
// ============================================================================
module life_tick_div #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] c_last = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = en && (cnt_q == c_last);

  // Next count: clear wins, wrap on tick, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_gen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : life_gen_sequencer
// Brief    : Command sequencer for the external Life next-generation datapath.
//            Loads seeds, single-steps or free-runs, counts generations and
//            stops on halt, limit, extinction, still life or period-2.
// Revision : 1.0 - initial release
// ============================================================================
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             halt,
  input  grid_t            seed,
  input  logic [GEN_W-1:0] gen_limit,
  output grid_t            dp_cur,
  input  grid_t            dp_next,
  output grid_t            grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic [2:0]       stop_code,
  output logic             done
);

  seq_state_t       state_q, state_d;
  grid_t            grid_q, grid_d;
  grid_t            prev_q, prev_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [GEN_W-1:0] limit_q, limit_d;
  stop_code_t       stop_q, stop_d;
  logic             done_q, done_d;
  // Sticky halt request: a one-cycle halt mid-interval still stops the run
  // at the following tick boundary.
  logic             halt_pend_q, halt_pend_d;

  logic             w_accept;
  logic             w_tick;
  logic             w_tick_clr;
  logic             w_halt_eff;
  logic [GEN_W-1:0] w_gen_inc;
  cmd_op_t          w_op;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy      = (state_q == S_STEP) || (state_q == S_RUN);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_op      = cmd_op_t'(cmd_op);
  assign w_halt_eff = halt_pend_q || halt;
  // Generation counter saturates at all-ones rather than wrapping.
  assign w_gen_inc = (&gen_q) ? gen_q : gen_q + GEN_W'(1);

  assign dp_cur    = grid_q;
  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign stop_code = stop_q;
  assign done      = done_q;

  life_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .clr   (w_tick_clr),
    .en    (state_q == S_RUN),
    .tick  (w_tick)
  );

  // Next-state, command decode and per-tick stop evaluation.
  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    prev_d      = prev_q;
    gen_d       = gen_q;
    limit_d     = limit_q;
    stop_d      = stop_q;
    done_d      = 1'b0;
    halt_pend_d = halt_pend_q;
    w_tick_clr  = 1'b0;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (w_accept) begin
          case (w_op)
            OP_LOAD: begin
              grid_d  = seed;
              prev_d  = seed;
              gen_d   = '0;
              stop_d  = STOP_NONE;
              state_d = S_HOLD;
            end
            OP_CLEAR: begin
              grid_d  = '0;
              prev_d  = '0;
              gen_d   = '0;
              stop_d  = STOP_NONE;
              state_d = S_IDLE;
            end
            OP_STEP: begin
              // Without a loaded grid there is nothing to step.
              if (state_q == S_HOLD) begin
                state_d = S_STEP;
              end
            end
            OP_RUN: begin
              if (state_q == S_HOLD) begin
                limit_d     = gen_limit;
                stop_d      = STOP_NONE;
                halt_pend_d = halt;
                w_tick_clr  = 1'b1;
                state_d     = S_RUN;
              end
            end
            default: ;
          endcase
        end
      end

      S_STEP: begin
        prev_d  = grid_q;
        grid_d  = dp_next;
        gen_d   = w_gen_inc;
        state_d = S_HOLD;
      end

      S_RUN: begin
        halt_pend_d = halt_pend_q || halt;
        if (w_tick) begin
          if (w_halt_eff) begin
            stop_d = STOP_HALT;
          end else begin
            prev_d = grid_q;
            grid_d = dp_next;
            gen_d  = w_gen_inc;
            if (dp_next == '0) begin
              stop_d = STOP_EXTINCT;
            end else if (dp_next == grid_q) begin
              stop_d = STOP_STILL;
            end else if ((dp_next == prev_q) && (gen_q != '0)) begin
              stop_d = STOP_PERIOD2;
            end else if ((limit_q != '0) && (w_gen_inc == limit_q)) begin
              stop_d = STOP_LIMIT;
            end
          end
          if (stop_d != STOP_NONE) begin
            done_d      = 1'b1;
            halt_pend_d = 1'b0;
            state_d     = S_HOLD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grid_q      <= '0;
      prev_q      <= '0;
      gen_q       <= '0;
      limit_q     <= '0;
      stop_q      <= STOP_NONE;
      done_q      <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      prev_q      <= prev_d;
      gen_q       <= gen_d;
      limit_q     <= limit_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      halt_pend_q <= halt_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Controls the combinational next-generation datapath on the 16x16 Life grid (256 bits).
- Loads a seed, then advances the grid one generation per tick, either in single steps or free-running.
- Counts generations and stops automatically on extinction, still life, period-2 oscillation, or a programmable generation limit.
- Sits between the top-level command source (testbench or board controls) and the datapath; it replaces the ad-hoc seed/evolve mux.

Parameters:
- TICK_DIV, 1: clock cycles per generation in RUN; legal range 1..65535.
- GEN_W, 16: width of the generation counter and the limit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_op  in  2  0=LOAD, 1=STEP, 2=RUN, 3=CLEAR
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- halt  in  1  level; stops RUN at the next tick boundary
- seed  in  256  grid loaded on LOAD; row r = bits [255-16r -: 16]
- gen_limit  in  GEN_W  sampled on RUN accept; 0 = no limit
- dp_cur  out  256  grid driven to the datapath (equals grid)
- dp_next  in  256  datapath next-generation result, combinational from dp_cur
- grid  out  256  current registered grid
- gen_count  out  GEN_W  generations since the last LOAD or CLEAR
- busy  out  1  high in STEP or RUN
- stop_code  out  3  0=none, 1=halt, 2=limit, 3=extinct, 4=still, 5=period2
- done  out  1  one-cycle pulse when RUN terminates

Behaviour:
- Reset (synchronous, active-high): state=IDLE, grid=0, prev_grid=0, gen_count=0, stop_code=0, done=0, tick counter=0. Reset mid-RUN abandons the run with no done pulse.
- States:
  - IDLE: no grid loaded.
  - HOLD: grid valid and idle.
  - STEP: a single generation in flight.
  - RUN: free-running.
- cmd_ready=1 in IDLE and HOLD; 0 in STEP and RUN. Commands presented while not ready are ignored; the requester must hold cmd_valid.
- LOAD (IDLE/HOLD): next cycle grid=seed, prev_grid=seed, gen_count=0, stop_code=0; go to HOLD.
- CLEAR (IDLE/HOLD): grid=0, prev_grid=0, gen_count=0, stop_code=0; go to IDLE.
- STEP or RUN accepted in IDLE: ignored (no grid); stay in IDLE.
- STEP (HOLD): enter STEP. Next cycle: prev_grid<=grid, grid<=dp_next, gen_count+1; return to HOLD. STEP ignores TICK_DIV and stop detection; stop_code is unchanged.
- RUN (HOLD): latch gen_limit, clear tick counter, clear stop_code, enter RUN.
- Tick in RUN: fires when tick counter == TICK_DIV-1, then the counter wraps to 0. The first tick falls TICK_DIV cycles after RUN accept.
- Evaluation on each tick, first match wins. Stop conditions are evaluated on dp_next before it is committed.
  - halt=1: no update, stop_code=1.
  - dp_next==0: commit, stop_code=3.
  - dp_next==grid: commit, stop_code=4.
  - dp_next==prev_grid and gen_count>=1: commit, stop_code=5.
  - Otherwise commit. If limit!=0 and the new gen_count==limit, stop_code=2.
  - "Commit" means prev_grid<=grid, grid<=dp_next, gen_count+1.
- Any nonzero stop_code set in RUN: done=1 for exactly one cycle, then return to HOLD. The RUN→HOLD transition happens in the same cycle the code is registered.
- gen_count saturates at all-ones and never wraps. In RUN, saturation with no limit set continues evolving.
- halt asserted in HOLD has no effect. halt held during the RUN accept cycle stops the run at the first tick.
- Grid pattern seeded as all zeros then RUN: stop_code=3 at the first tick, gen_count=1.
- dp_cur is a direct copy of the grid register.
- busy = (state==STEP || state==RUN).

Decomposition:
- Package life_pkg holds:
  - typedef grid_t = logic [255:0]
  - enums cmd_op_t, seq_state_t, stop_code_t
  - constants GRID_DIM=16, GRID_BITS=256
- One sub-module, life_tick_div: parameterised tick counter with clear and enable inputs and a tick pulse output.
- The datapath itself stays external.

Test Plan:
- LOAD of the block still life (rows 1-2, cols 1-2 set), then RUN, TICK_DIV=1 → done after 1 tick, stop_code=4, gen_count=1, grid unchanged.
- LOAD of a vertical blinker (rows 1-3, bit 13 set), then RUN, limit=0 → the horizontal phase follows at gen 1; at gen 2 stop_code=5, gen_count=2, grid equals the seed.
- LOAD of a single cell, then STEP → busy high for 1 cycle, grid=0, gen_count=1, stop_code=0, no done pulse.
- Glider seed, RUN, limit=5, TICK_DIV=4 → updates at cycles 4, 8, 12, 16, 20 after accept; done at the 5th update with stop_code=2.
- Glider RUN with halt raised for 1 cycle mid-interval → holds through the interval, stops at the next tick with stop_code=1 and grid unchanged at that tick. Also: cmd_valid during RUN is never accepted.
- Reset pulsed mid-RUN at gen 3 → next cycle grid=0, gen_count=0, state IDLE, no done pulse. Follow-up STEP is ignored; LOAD is accepted.
